// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, oversampled by FREQ_DIV) feeding a show-ahead receive FIFO.
// Framing errors and FIFO overruns are reported as single-cycle pulses.
module uart_rx_fifo #(
  parameter int FREQ_DIV   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(FREQ_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_HALF = CW'(FREQ_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FREQ_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // Handshake: a byte leaves the FIFO on every rising edge where data_valid && data_ready.
  logic          sync1_q, sync1_d;
  logic          rxs_q, rxs_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;

  logic push, pop, push_ok, full, empty;

  always_comb begin
    sync1_d     = rxd;
    rxs_d       = sync1_q;
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_ONE;
    idx_d       = idx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = rxs_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rxs_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // A line held low must not be decoded as a stream of frames.
        cnt_d = '0;
        if (rxs_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop       = !empty && data_ready;
    push_ok   = push && (!full || pop);
    overrun_d = push && full && !pop;
    wr_ptr_d  = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    mem_d     = mem_q;
    if (push_ok) mem_d[wr_ptr_q[AW-1:0]] = shift_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      sync1_q     <= sync1_d;
      rxs_q       <= rxs_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign data_valid = !empty;
  assign data_out   = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a serial driver feeds frames, a line-level model predicts bytes,
// and an independent monitor pops and checks every delivered byte against the expected queue.
module tb_uart_rx_fifo;

  localparam int FD    = 16;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx_fifo #(.FREQ_DIV(FD), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int exp_ferr = 0;
  int exp_ovr = 0;
  int ferr_seen = 0;
  int ovr_seen = 0;
  int valid_cycles = 0;
  int busy_cycles = 0;
  bit gen_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (FD) tick();
  endtask

  // Serial driver; the model decides the frame's fate in the middle of the stop bit.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    rxd = stop_bit;
    repeat (FD / 2) tick();
    if (!stop_bit) exp_ferr++;
    else if (exp_q.size() >= DEPTH) exp_ovr++;
    else exp_q.push_back(b);
    repeat (FD - FD / 2) tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor: pops and compares whenever the DUT hands over a byte.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (frame_err) ferr_seen++;
        if (overrun) ovr_seen++;
        if (data_valid) valid_cycles++;
        if (busy) busy_cycles++;
        if (data_valid && data_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop: got 0x%0h expected no byte", data_out);
          end else begin
            check("pop_data", data_out, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int v0, b0;
    logic [7:0] rb;
    rst = 1'b1;
    rxd = 1'b1;
    data_ready = 1'b0;
    repeat (4) tick();
    check("rst_data_valid", data_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    check("rst_data_out", data_out, 0);
    rst = 1'b0;
    repeat (4) tick();

    // Single byte with consumer always ready
    data_ready = 1'b1;
    v0 = valid_cycles;
    send_byte(8'h41, 1'b1);
    repeat (2 * FD) tick();
    check("single_valid_cycles", valid_cycles - v0, 1);
    check("single_ferr", ferr_seen, exp_ferr);
    check("single_ovr", ovr_seen, exp_ovr);

    // Short low glitch
    b0 = busy_cycles;
    v0 = valid_cycles;
    rxd = 1'b0;
    repeat (3) tick();
    rxd = 1'b1;
    repeat (2 * FD) tick();
    check("glitch_busy_seen", busy_cycles > b0, 1);
    check("glitch_busy_end", busy, 0);
    check("glitch_no_valid", valid_cycles - v0, 0);
    check("glitch_ferr", ferr_seen, exp_ferr);

    // Framing error followed by a long break
    send_byte(8'hA5, 1'b0);
    repeat (40) tick();
    check("break_busy", busy, 1);
    check("break_no_valid", data_valid, 0);
    rxd = 1'b1;
    repeat (8) tick();
    check("break_busy_end", busy, 0);
    check("break_ferr", ferr_seen, exp_ferr);

    // Overrun with a stalled consumer
    data_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    repeat (4) tick();
    check("ovr_count", ovr_seen, exp_ovr);
    check("ovr_full_valid", data_valid, 1);
    data_ready = 1'b1;
    drain();
    repeat (2) tick();
    check("ovr_drained_valid", data_valid, 0);

    // Reset mid-frame with bytes queued
    data_ready = 1'b0;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    rb = 8'h3C;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(rb[i]);
    rxd = rb[3];
    repeat (FD / 2) tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    check("midrst_valid", data_valid, 0);
    check("midrst_busy", busy, 0);
    rxd = 1'b1;
    repeat (12 * FD) tick();
    check("midrst_no_byte", data_valid, 0);
    data_ready = 1'b1;
    send_byte(8'h5A, 1'b1);
    drain();

    // Back-to-back frames with a toggling consumer
    gen_done = 1'b0;
    fork
      begin
        send_byte(8'h41, 1'b1);
        send_byte(8'h42, 1'b1);
        send_byte(8'h43, 1'b1);
        gen_done = 1'b1;
      end
      begin
        while (!gen_done) begin
          data_ready = ~data_ready;
          tick();
        end
      end
    join
    data_ready = 1'b1;
    drain();
    check("toggle_ovr", ovr_seen, exp_ovr);

    // Random bytes, random gaps, random consumer
    gen_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          rxd = 1'b1;
          repeat ($urandom_range(0, 20)) tick();
          send_byte(8'($urandom_range(0, 255)), 1'b1);
        end
        gen_done = 1'b1;
      end
      begin
        while (!gen_done) begin
          data_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    data_ready = 1'b1;
    drain();

    repeat (4) tick();
    check("final_ferr", ferr_seen, exp_ferr);
    check("final_ovr", ovr_seen, exp_ovr);
    check("final_valid", data_valid, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
